// File: rtl/mem_arbiter_if.sv
// Memory command/response port shared by the arbiter (master) and the memory (slave).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) single-port memory arbiter with busy timeout.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise fetch always wins ties.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_gnt,
  output logic                fetch_rvalid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  mem_arbiter_if.master       mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_F,
    BUSY_L
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_be;
  logic                r_fetch_rvalid;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic w_pick_ls;
  logic w_can_grant;
  logic w_timeout;

`ifdef MEM_ARB_RR_EN
  logic r_prefer_ls;

  assign w_pick_ls = ls_req && (!fetch_req || r_prefer_ls);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prefer_ls <= 1'b0;
    end else if (fetch_gnt) begin
      r_prefer_ls <= 1'b1;
    end else if (ls_gnt) begin
      r_prefer_ls <= 1'b0;
    end
  end
`else
  assign w_pick_ls = ls_req && !fetch_req;
`endif

  // Grants are combinational, so reset_n gates them to keep every output low during reset.
  assign w_can_grant = (r_state == IDLE) && ce && reset_n;
  assign fetch_gnt   = w_can_grant && fetch_req && !w_pick_ls;
  assign ls_gnt      = w_can_grant && w_pick_ls;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_fetch_rvalid <= 1'b0;
      r_ls_rvalid    <= 1'b0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
    end else begin
      r_fetch_rvalid <= 1'b0;
      r_ls_rvalid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fetch_gnt) begin
            r_state     <= BUSY_F;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= fetch_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
          end else if (ls_gnt) begin
            r_state     <= BUSY_L;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ls_we;
            r_mem_addr  <= ls_addr;
            r_mem_wdata <= ls_wdata;
            r_mem_be    <= ls_be;
          end
        end
        BUSY_F, BUSY_L: begin
          // mem_ready wins over a simultaneous timeout.
          if (mem.mem_ready || w_timeout) begin
            r_state        <= IDLE;
            r_mem_req      <= 1'b0;
            r_fetch_rvalid <= (r_state == BUSY_F);
            r_ls_rvalid    <= (r_state == BUSY_L);
            r_err          <= !mem.mem_ready;
            r_rdata        <= (mem.mem_ready && !r_mem_we) ? mem.mem_rdata : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_rvalid  = r_fetch_rvalid;
  assign ls_rvalid     = r_ls_rvalid;
  assign rdata         = r_rdata;
  assign err           = r_err;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; honours MEM_ARB_RR_EN like the RTL.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic              ce;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .ls_req       (ls_req),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_be        (ls_be),
    .ls_gnt       (ls_gnt),
    .ls_rvalid    (ls_rvalid),
    .rdata        (rdata),
    .err          (err),
    .mem          (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
    #2;
    step(); step();
    reset_n = 1'b1; ce = 1'b1;
    #1;
    n_checks++;
    if ({fetch_gnt, ls_gnt, fetch_rvalid, ls_rvalid, err, mem_bus.mem_req, mem_bus.mem_we} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
        {fetch_gnt, ls_gnt, fetch_rvalid, ls_rvalid, err, mem_bus.mem_req, mem_bus.mem_we});
    end
    n_checks++;
    if (rdata !== 32'h0 || mem_bus.mem_addr !== 32'h0 || mem_bus.mem_be !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h addr=%h be=%h want 0", rdata, mem_bus.mem_addr, mem_bus.mem_be);
    end
  endtask

  task automatic test_fetch();
    fetch_req = 1'b1; fetch_addr = 32'h100;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gnt: got f=%b l=%b want f=1 l=0", fetch_gnt, ls_gnt);
    end
    step();
    fetch_req = 1'b0;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b0 || mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_be !== 4'hF) begin
      n_fail++; $display("FAIL fetch_cmd: gnt=%b req=%b we=%b be=%h want 0 1 0 f",
        fetch_gnt, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be);
    end
    step();
    n_checks++;
    if (mem_bus.mem_addr !== 32'h100 || mem_bus.mem_req !== 1'b1 || fetch_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_hold: addr=%h req=%b rvalid=%b want 100 1 0",
        mem_bus.mem_addr, mem_bus.mem_req, fetch_rvalid);
    end
    step();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF;
    step();
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    n_checks++;
    if (fetch_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF || err !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp: rv=%b lrv=%b rdata=%h err=%b req=%b want 1 0 deadbeef 0 0",
        fetch_rvalid, ls_rvalid, rdata, err, mem_bus.mem_req);
    end
    step();
    n_checks++;
    if (fetch_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_pulse_hold: rv=%b rdata=%h want 0 deadbeef", fetch_rvalid, rdata);
    end
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_be = 4'h3;
    #1;
    n_checks++;
    if (ls_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin
      n_fail++; $display("FAIL store_gnt: got l=%b f=%b want l=1 f=0", ls_gnt, fetch_gnt);
    end
    step();
    ls_req = 1'b0;
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_be !== 4'h3 ||
        mem_bus.mem_addr !== 32'h200 || mem_bus.mem_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL store_cmd: req=%b we=%b be=%h addr=%h wdata=%h want 1 1 3 200 12345678",
        mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    step();
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    n_checks++;
    if (ls_rvalid !== 1'b1 || fetch_rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL store_resp: lrv=%b frv=%b rdata=%h err=%b want 1 0 0 0",
        ls_rvalid, fetch_rvalid, rdata, err);
    end
    ls_we = 1'b0;
  endtask

  task automatic test_back_to_back();
`ifdef MEM_ARB_RR_EN
    logic [3:0] exp_ls = 4'b1010;
`else
    logic [3:0] exp_ls = 4'b0000;
`endif
    fetch_req = 1'b1; fetch_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fetch_gnt !== ~exp_ls[i] || ls_gnt !== exp_ls[i]) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got f=%b l=%b want f=%b l=%b",
          i, fetch_gnt, ls_gnt, ~exp_ls[i], exp_ls[i]);
      end
      step();
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1000 + i;
      step();
      mem_bus.mem_ready = 1'b0;
      n_checks++;
      if (ls_rvalid !== exp_ls[i] || fetch_rvalid !== ~exp_ls[i] || rdata !== 32'h1000 + i || err !== 1'b0) begin
        n_fail++; $display("FAIL b2b_resp[%0d]: frv=%b lrv=%b rdata=%h err=%b want lrv=%b rdata=%h err=0",
          i, fetch_rvalid, ls_rvalid, rdata, err, exp_ls[i], 32'h1000 + i);
      end
    end
    fetch_req = 1'b0; ls_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int hit = 0;
    fetch_req = 1'b1; fetch_addr = 32'h600;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1) begin
      n_fail++; $display("FAIL to_gnt: got %b want 1", fetch_gnt);
    end
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      step();
      fetch_req = 1'b0;
      if (fetch_rvalid === 1'b1) hit = k;
    end
    n_checks++;
    if (hit !== 17) begin
      n_fail++; $display("FAIL to_latency: rvalid %0d cycles after gnt want 17", hit);
    end
    n_checks++;
    if (err !== 1'b1 || rdata !== 32'h0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL to_resp: err=%b rdata=%h req=%b want 1 0 0", err, rdata, mem_bus.mem_req);
    end
  endtask

  task automatic test_timeout_edge();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h700;
    #1;
    n_checks++;
    if (ls_gnt !== 1'b1) begin
      n_fail++; $display("FAIL edge_gnt: got %b want 1 (fsm idle after abort)", ls_gnt);
    end
    step();
    ls_req = 1'b0;
    for (int k = 2; k <= 16; k++) step();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || ls_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL edge_busy16: req=%b lrv=%b want 1 0", mem_bus.mem_req, ls_rvalid);
    end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hA5A50F0F;
    step();
    mem_bus.mem_ready = 1'b0;
    n_checks++;
    if (ls_rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hA5A50F0F) begin
      n_fail++; $display("FAIL edge_resp: lrv=%b err=%b rdata=%h want 1 0 a5a50f0f", ls_rvalid, err, rdata);
    end
  endtask

  task automatic test_idle_ready();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h55;
    step(); step();
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || fetch_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || rdata !== 32'hA5A50F0F) begin
      n_fail++; $display("FAIL idle_ready: req=%b frv=%b lrv=%b rdata=%h want 0 0 0 a5a50f0f",
        mem_bus.mem_req, fetch_rvalid, ls_rvalid, rdata);
    end
    mem_bus.mem_ready = 1'b0;
  endtask

  task automatic test_ce();
    ce = 1'b0; fetch_req = 1'b1; ls_req = 1'b1; fetch_addr = 32'h800; ls_addr = 32'h900;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
      n_fail++; $display("FAIL ce_block: f=%b l=%b want 0 0", fetch_gnt, ls_gnt);
    end
    step();
    n_checks++;
    if (fetch_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL ce_block2: f=%b l=%b req=%b want 0 0 0", fetch_gnt, ls_gnt, mem_bus.mem_req);
    end
    ce = 1'b1;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      n_fail++; $display("FAIL ce_grant: f=%b l=%b want 1 0", fetch_gnt, ls_gnt);
    end
    step();
    fetch_req = 1'b0; ls_req = 1'b0; ce = 1'b0;
    step(); step();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h800) begin
      n_fail++; $display("FAIL ce_busy: req=%b addr=%h want 1 800", mem_bus.mem_req, mem_bus.mem_addr);
    end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hCAFE0001;
    step();
    mem_bus.mem_ready = 1'b0;
    n_checks++;
    if (fetch_rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || err !== 1'b0) begin
      n_fail++; $display("FAIL ce_resp: frv=%b rdata=%h err=%b want 1 cafe0001 0", fetch_rvalid, rdata, err);
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_busy();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
    #1;
    n_checks++;
    if (ls_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rb_gnt: got %b want 1", ls_gnt);
    end
    step();
    ls_req = 1'b0;
    step();
    fetch_req = 1'b1; ls_req = 1'b1; fetch_addr = 32'hA00;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({fetch_gnt, ls_gnt, fetch_rvalid, ls_rvalid, err, mem_bus.mem_req, mem_bus.mem_we} !== 7'b0 ||
        rdata !== 32'h0 || mem_bus.mem_addr !== 32'h0 || mem_bus.mem_be !== 4'h0) begin
      n_fail++; $display("FAIL rb_outputs: ctl=%b rdata=%h addr=%h be=%h want all 0",
        {fetch_gnt, ls_gnt, fetch_rvalid, ls_rvalid, err, mem_bus.mem_req, mem_bus.mem_we},
        rdata, mem_bus.mem_addr, mem_bus.mem_be);
    end
    step(); step();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1 || ls_gnt !== 1'b0 || ls_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rb_tie: f=%b l=%b lrv=%b want 1 0 0", fetch_gnt, ls_gnt, ls_rvalid);
    end
    step();
    fetch_req = 1'b0; ls_req = 1'b0;
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h7;
    step();
    mem_bus.mem_ready = 1'b0;
    n_checks++;
    if (fetch_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || rdata !== 32'h7) begin
      n_fail++; $display("FAIL rb_resp: frv=%b lrv=%b rdata=%h want 1 0 7", fetch_rvalid, ls_rvalid, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    test_idle_ready();
    test_ce();
    test_reset_busy();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles before abort; legal range 2..255.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ce  input  1  arbiter enable; low blocks new grants only.
REQ-007 fetch_req  input  1  fetch requester wants a read.
REQ-008 fetch_addr  input  ADDR_W  fetch read address.
REQ-009 fetch_gnt  output  1  fetch request accepted this cycle.
REQ-010 fetch_rvalid  output  1  fetch response valid, one-cycle pulse.
REQ-011 ls_req  input  1  load/store requester wants an access.
REQ-012 ls_we  input  1  1 = store, 0 = load.
REQ-013 ls_addr  input  ADDR_W  load/store address.
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_be  input  DATA_W/8  store byte enables.
REQ-016 ls_gnt  output  1  load/store request accepted this cycle.
REQ-017 ls_rvalid  output  1  load/store response valid, one-cycle pulse (stores included).
REQ-018 rdata  output  DATA_W  shared response data, qualified by either rvalid.
REQ-019 err  output  1  response is a timeout abort; qualified by either rvalid.
REQ-020 mem_req, mem_we, mem_addr, mem_wdata, mem_be  outputs  1/1/ADDR_W/DATA_W/DATA_W/8  memory port command.
REQ-021 mem_ready  input  1  memory completes the command this cycle.
REQ-022 mem_rdata  input  DATA_W  read data, valid with mem_ready.

Function
REQ-023 FSM states SHALL be IDLE, BUSY_F, BUSY_L.
REQ-024 In IDLE with ce=1, the arbiter SHALL assert the winner's gnt combinationally, capture the winner's command at the clock edge, and enter BUSY_F or BUSY_L.
REQ-025 Only one gnt SHALL be high per cycle; no gnt SHALL be high outside IDLE or while ce=0.
REQ-026 Fetch commands SHALL be captured with mem_we=0 and mem_be all-ones.
REQ-027 In BUSY_x, mem_req SHALL be 1 and the mem_* command SHALL be driven from the captured registers, stable until completion.
REQ-028 In IDLE, mem_req SHALL be 0.
REQ-029 mem_ready in BUSY_x SHALL return the FSM to IDLE; the next cycle SHALL pulse x_rvalid with rdata = captured mem_rdata (stores: rdata=0) and err=0.
REQ-030 Minimum turnaround SHALL be: gnt cycle N, mem_ready cycle N+1, rvalid cycle N+2, next gnt possible in cycle N+2.
REQ-031 A BUSY cycle counter SHALL clear on entry to BUSY; on the TIMEOUT-th BUSY cycle without mem_ready, the FSM SHALL return to IDLE and the next cycle SHALL pulse x_rvalid with err=1 and rdata=0.
REQ-032 mem_ready coinciding with the TIMEOUT-th cycle SHALL count as normal completion with err=0.
REQ-033 mem_ready in IDLE SHALL be ignored.
REQ-034 ce falling during BUSY SHALL NOT abort the access.
REQ-035 rdata and err SHALL hold their last values when no rvalid is high.

Reset
REQ-036 reset_n low SHALL immediately force IDLE, clear the counter, captured command, rdata and err to 0, and set all outputs to 0.
REQ-037 reset_n asserted mid-BUSY SHALL drop the access; no rvalid SHALL follow it.
REQ-038 The round-robin pointer SHALL reset to "fetch preferred".

Configuration
REQ-039 Macro MEM_ARB_RR_EN defined: when both requests are present in IDLE, the requester not granted last wins; after reset, fetch wins.
REQ-040 Macro MEM_ARB_RR_EN undefined: fetch always wins ties; the pointer SHALL not exist.

Verification
REQ-041 fetch_req, addr 0x100, mem_ready 3 cycles later with mem_rdata 0xDEADBEEF -> fetch_gnt 1 cycle, mem_addr 0x100 held, fetch_rvalid with rdata 0xDEADBEEF, err=0.
REQ-042 ls store addr 0x200, wdata 0x12345678, be 0x3, mem_ready next cycle -> mem_we=1, mem_be 0x3, ls_rvalid at N+2, rdata=0.
REQ-043 Both requests held for 4 accesses -> RR_EN: grants F,L,F,L; undefined: F,F,F,F.
REQ-044 No mem_ready, TIMEOUT=16 -> rvalid with err=1 exactly 17 cycles after gnt; FSM in IDLE.
REQ-045 reset_n low 2 cycles into BUSY_L -> all outputs 0 immediately, no ls_rvalid, fetch-preferred on next tie.
REQ-046 ce=0 with both requests present -> no gnt; ce=1 -> grant the same cycle.
